// File: rtl/axis_video_crop.sv
// AXI4-Stream video crop: forwards one rectangular window per frame and regenerates SOF/EOL.
// Define CROP_STATUS_EN to add the meas_width/meas_height input-geometry outputs.
module axis_video_crop #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  aclken,
  input  logic [CNT_WIDTH-1:0]  crop_x,
  input  logic [CNT_WIDTH-1:0]  crop_y,
  input  logic [CNT_WIDTH-1:0]  crop_w,
  input  logic [CNT_WIDTH-1:0]  crop_h,
  input  logic [DATA_WIDTH-1:0] s_axis_video_tdata,
  input  logic                  s_axis_video_tvalid,
  output logic                  s_axis_video_tready,
  input  logic                  s_axis_video_tuser,
  input  logic                  s_axis_video_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_video_tdata,
  output logic                  m_axis_video_tvalid,
  input  logic                  m_axis_video_tready,
  output logic                  m_axis_video_tuser,
  output logic                  m_axis_video_tlast,
  output logic                  err_short_line,
  output logic                  err_sof_early
`ifdef CROP_STATUS_EN
  ,
  output logic [CNT_WIDTH-1:0]  meas_width,
  output logic [CNT_WIDTH-1:0]  meas_height
`endif
);

  typedef enum logic {WAIT_SOF, ACTIVE} state_t;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_x, r_y, w_x_nxt, w_y_nxt;
  logic [CNT_WIDTH-1:0]  r_cx, r_cy, r_cw, r_ch;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic                  r_m_tvalid, r_m_tuser, r_m_tlast;
  logic                  r_err_short, r_err_sof;

  logic                  w_s_tready, w_accept, w_sof, w_count, w_fwd;
  logic                  w_in_win, w_last_col, w_short, w_err_sof_set;
  logic [CNT_WIDTH-1:0]  w_x, w_y, w_cx, w_cy, w_cw, w_ch, w_x_inc, w_y_inc;
  logic [CNT_WIDTH:0]    w_x_end, w_y_end, w_x_plus1;

  assign w_s_tready = (~r_m_tvalid | m_axis_video_tready) & aclken;
  assign w_accept   = s_axis_video_tvalid & w_s_tready;
  assign w_sof      = w_accept & s_axis_video_tuser;

  // A SOF beat is pixel (0,0) of the new frame and is judged against the configuration it latches.
  assign w_count = w_accept & (s_axis_video_tuser | (r_state == ACTIVE));
  assign w_x     = s_axis_video_tuser ? '0 : r_x;
  assign w_y     = s_axis_video_tuser ? '0 : r_y;
  assign w_cx    = s_axis_video_tuser ? crop_x : r_cx;
  assign w_cy    = s_axis_video_tuser ? crop_y : r_cy;
  assign w_cw    = s_axis_video_tuser ? crop_w : r_cw;
  assign w_ch    = s_axis_video_tuser ? crop_h : r_ch;

  assign w_x_end   = {1'b0, w_cx} + {1'b0, w_cw};
  assign w_y_end   = {1'b0, w_cy} + {1'b0, w_ch};
  assign w_x_plus1 = {1'b0, w_x} + (CNT_WIDTH + 1)'(1);
  assign w_x_inc   = (w_x == CNT_MAX) ? w_x : w_x + CNT_WIDTH'(1);
  assign w_y_inc   = (w_y == CNT_MAX) ? w_y : w_y + CNT_WIDTH'(1);

  assign w_in_win   = (w_x >= w_cx) && ({1'b0, w_x} < w_x_end) &&
                      (w_y >= w_cy) && ({1'b0, w_y} < w_y_end);
  assign w_last_col = (w_x_plus1 == w_x_end);
  assign w_short    = s_axis_video_tlast && (w_x_plus1 < w_x_end);
  assign w_fwd      = w_count & w_in_win;

  assign w_err_sof_set = w_sof && (r_state == ACTIVE) && (r_ch != '0) &&
                         ({1'b0, r_y} < ({1'b0, r_cy} + {1'b0, r_ch}));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    if (w_sof) w_state_nxt = ACTIVE;
    if (w_count) begin
      if (s_axis_video_tlast) begin
        w_x_nxt = '0;
        w_y_nxt = w_y_inc;
      end else begin
        w_x_nxt = w_x_inc;
        w_y_nxt = w_y;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)    r_state <= WAIT_SOF;
    else if (aclken) r_state <= w_state_nxt;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_x         <= '0;
      r_y         <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_cw        <= '0;
      r_ch        <= '0;
      r_m_tdata   <= '0;
      r_m_tvalid  <= 1'b0;
      r_m_tuser   <= 1'b0;
      r_m_tlast   <= 1'b0;
      r_err_short <= 1'b0;
      r_err_sof   <= 1'b0;
    end else if (aclken) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_x <= w_x_nxt;
      r_y <= w_y_nxt;
      if (w_sof) begin
        r_cx <= crop_x;
        r_cy <= crop_y;
        r_cw <= crop_w;
        r_ch <= crop_h;
      end
      if (w_fwd) begin
        r_m_tdata  <= s_axis_video_tdata;
        r_m_tvalid <= 1'b1;
        r_m_tuser  <= (w_x == w_cx) && (w_y == w_cy);
        r_m_tlast  <= w_last_col | s_axis_video_tlast;
      end else if (m_axis_video_tready) begin
        r_m_tvalid <= 1'b0;
      end
      if (w_fwd && w_short) r_err_short <= 1'b1;
      if (w_err_sof_set)    r_err_sof   <= 1'b1;
    end
  end

`ifdef CROP_STATUS_EN
  logic                 r_seen_sof;
  logic [CNT_WIDTH-1:0] r_meas_w, r_meas_h;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_seen_sof <= 1'b0;
      r_meas_w   <= '0;
      r_meas_h   <= '0;
    end else if (aclken) begin
      if (w_count && s_axis_video_tlast) r_meas_w <= w_x_inc;
      if (w_sof) begin
        r_seen_sof <= 1'b1;
        if (r_seen_sof) r_meas_h <= r_y;
      end
    end
  end

  assign meas_width  = r_meas_w;
  assign meas_height = r_meas_h;
`else
  // Status measurement disabled: no extra ports or registers.
`endif

  assign s_axis_video_tready = w_s_tready;
  assign m_axis_video_tdata  = r_m_tdata;
  assign m_axis_video_tvalid = r_m_tvalid;
  assign m_axis_video_tuser  = r_m_tuser;
  assign m_axis_video_tlast  = r_m_tlast;
  assign err_short_line      = r_err_short;
  assign err_sof_early       = r_err_sof;

endmodule
